// File: rtl/vaddsub_deskew_pkg.sv
// Shared types and constants for the staggered vector add/sub deskew block.
package vaddsub_deskew_pkg;

  localparam int VLEN_BITS  = 256;
  localparam int SLICES     = 32;
  localparam int SKEW_DEPTH = 32;

  typedef enum logic [2:0] {
    SEW8   = 3'd0,
    SEW16  = 3'd1,
    SEW32  = 3'd2,
    SEW64  = 3'd3,
    SEW128 = 3'd4,
    SEW256 = 3'd5
  } sew_e;

  // Bytes per element; the two reserved codes behave as a single 256-bit element.
  function automatic logic [5:0] sew_to_bytes(input logic [2:0] sew);
    case (sew)
      SEW8:    return 6'd1;
      SEW16:   return 6'd2;
      SEW32:   return 6'd4;
      SEW64:   return 6'd8;
      SEW128:  return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/vaddsub_deskew_slice_deskew.sv
// Delay line for one adder byte slice plus its carry-out. Slice p of the adder
// is late by p cycles, so it is given DEPTH = 32-p stages to line up with the rest.
module vaddsub_deskew_slice_deskew #(
  parameter int DEPTH = 1
) (
  input  logic       clk_i,
  input  logic [8:0] d_i,
  output logic [8:0] q_o
);

  logic [8:0] stage_q [DEPTH];

  // Plain shift register; contents only matter when the tag pipeline marks them valid.
  always_ff @(posedge clk_i) begin
    stage_q[0] <= d_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vaddsub_deskew.sv
// Realigns the skewed sum/carry slices of the staggered adder, packs per-element
// carry-outs, queues results, and sequences the adder's enable/op/sew so that an
// operation never sees its configuration change while its slices are in flight.
module vaddsub_deskew
  import vaddsub_deskew_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic                 issue_op_i,
  input  logic [2:0]           issue_sew_i,
  input  logic [TAG_W-1:0]     issue_tag_i,
  output logic                 addsub_en_o,
  output logic                 addsub_op_o,
  output logic [2:0]           addsub_sew_o,
  input  logic [VLEN_BITS-1:0] sum_i,
  input  logic [SLICES:0]      cout_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [VLEN_BITS-1:0] result_data_o,
  output logic [SLICES-1:0]    result_carry_o,
  output logic [TAG_W-1:0]     result_tag_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [SKEW_DEPTH-1:0] pipe_vld_q;
  logic [2:0]            pipe_sew_q [SKEW_DEPTH];
  logic [TAG_W-1:0]      pipe_tag_q [SKEW_DEPTH];

  logic [3:0]            cfg_q;
  logic [CNT_W-1:0]      outstanding_q;
  logic                  busy;
  logic                  cfg_mismatch;
  logic                  fire;
  logic                  pop;
  logic                  wr_en;

  logic [VLEN_BITS-1:0]  sum_al;
  logic [SLICES-1:0]     cout_al;
  logic [SLICES-1:0]     carry_packed;
  logic [5:0]            sew_bytes;
  int                    carry_idx;

  logic [VLEN_BITS-1:0]  fifo_data  [FIFO_DEPTH];
  logic [SLICES-1:0]     fifo_carry [FIFO_DEPTH];
  logic [TAG_W-1:0]      fifo_tag   [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q;

  // cout_i[0] is the adder's carry-in and carries no result information.
  logic unused_cin;
  assign unused_cin = cout_i[0];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar p = 0; p < SLICES; p++) begin : g_slice
    logic [8:0] slice_q;

    vaddsub_deskew_slice_deskew #(
      .DEPTH(SKEW_DEPTH - p)
    ) u_slice (
      .clk_i(clk_i),
      .d_i  ({cout_i[p+1], sum_i[8*p +: 8]}),
      .q_o  (slice_q)
    );

    assign sum_al[8*p +: 8] = slice_q[7:0];
    assign cout_al[p]       = slice_q[8];
  end

  // Stage k holds the op fired k+1 cycles ago; stages 0..30 mean slices are still computing.
  assign busy         = |pipe_vld_q[SKEW_DEPTH-2:0];
  assign wr_en        = pipe_vld_q[SKEW_DEPTH-1];
  assign cfg_mismatch = ({issue_op_i, issue_sew_i} != cfg_q);

  assign issue_ready_o = (outstanding_q < CNT_W'(FIFO_DEPTH)) & ~(busy & cfg_mismatch);
  assign fire          = issue_valid_i & issue_ready_o;
  assign pop           = result_valid_o & result_ready_i;

  assign addsub_en_o  = fire | busy;
  assign addsub_op_o  = fire ? issue_op_i  : cfg_q[3];
  assign addsub_sew_o = fire ? issue_sew_i : cfg_q[2:0];

  // Valid bits of the tag pipeline; clearing them on reset drops all in-flight work.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q <= {pipe_vld_q[SKEW_DEPTH-2:0], fire};
    end
  end

  // Payload of the tag pipeline travels with the valid bits and needs no reset.
  always_ff @(posedge clk_i) begin
    pipe_sew_q[0] <= issue_sew_i;
    pipe_tag_q[0] <= issue_tag_i;
    for (int i = 1; i < SKEW_DEPTH; i++) begin
      pipe_sew_q[i] <= pipe_sew_q[i-1];
      pipe_tag_q[i] <= pipe_tag_q[i-1];
    end
  end

  // Adder configuration seen by in-flight ops; only an accepted op may change it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q <= {1'b1, SEW8};
    end else if (fire) begin
      cfg_q <= {issue_op_i, issue_sew_i};
    end
  end

  // Credit counter: ops accepted but not yet consumed, bounding FIFO occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else if (fire && !pop) begin
      outstanding_q <= outstanding_q + CNT_W'(1);
    end else if (!fire && pop) begin
      outstanding_q <= outstanding_q - CNT_W'(1);
    end
  end

  // Element k's carry-out is the carry of its top byte, slice (k+1)*bytes-1.
  always_comb begin
    carry_packed = '0;
    carry_idx    = 0;
    sew_bytes    = sew_to_bytes(pipe_sew_q[SKEW_DEPTH-1]);
    for (int k = 0; k < SLICES; k++) begin
      if ((k + 1) * int'(sew_bytes) <= SLICES) begin
        carry_idx       = (k + 1) * int'(sew_bytes) - 1;
        carry_packed[k] = cout_al[carry_idx[4:0]];
      end
    end
  end

  // Result storage; written when an aligned op leaves the last pipeline stage.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      fifo_data[wr_ptr_q]  <= sum_al;
      fifo_carry[wr_ptr_q] <= carry_packed;
      fifo_tag[wr_ptr_q]   <= pipe_tag_q[SKEW_DEPTH-1];
    end
  end

  // FIFO pointers and occupancy; simultaneous write and pop are both honoured.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({wr_en, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign result_valid_o = (fifo_cnt_q != '0);
  assign result_data_o  = result_valid_o ? fifo_data[rd_ptr_q]  : '0;
  assign result_carry_o = result_valid_o ? fifo_carry[rd_ptr_q] : '0;
  assign result_tag_o   = result_valid_o ? fifo_tag[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_vaddsub_deskew.sv
// Bench for vaddsub_deskew: plays the staggered adder, keeps a transaction-level
// model of acceptance, credit, interlock and result ordering, and checks every cycle.
module tb_vaddsub_deskew;

  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           issue_valid_i;
  logic           issue_ready_o;
  logic           issue_op_i;
  logic [2:0]     issue_sew_i;
  logic [TW-1:0]  issue_tag_i;
  logic           addsub_en_o;
  logic           addsub_op_o;
  logic [2:0]     addsub_sew_o;
  logic [255:0]   sum_i;
  logic [32:0]    cout_i;
  logic           result_valid_o;
  logic           result_ready_i;
  logic [255:0]   result_data_o;
  logic [31:0]    result_carry_o;
  logic [TW-1:0]  result_tag_o;

  logic [255:0]   a_in;
  logic [255:0]   b_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  vaddsub_deskew #(.FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_sew_i(issue_sew_i), .issue_tag_i(issue_tag_i),
    .addsub_en_o(addsub_en_o), .addsub_op_o(addsub_op_o), .addsub_sew_o(addsub_sew_o),
    .sum_i(sum_i), .cout_i(cout_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_data_o(result_data_o), .result_carry_o(result_carry_o), .result_tag_o(result_tag_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Element-wise add/sub; per-byte carries (borrows for sub) as the adder reports them.
  task automatic adder_model(input logic op, input logic [2:0] sew,
                             input logic [255:0] a, input logic [255:0] b,
                             output logic [255:0] sum, output logic [32:0] cv,
                             output logic [31:0] pk);
    int eb;
    int nel;
    logic [256:0] al;
    logic [256:0] bl;
    logic [256:0] r;
    eb  = (sew > 3'd5) ? 32 : (1 << sew);
    nel = 32 / eb;
    sum = '0;
    cv  = '0;
    pk  = '0;
    for (int e = 0; e < nel; e++) begin
      for (int j = 0; j < eb; j++) begin
        al = '0;
        bl = '0;
        for (int q = 0; q <= j; q++) begin
          al[8*q +: 8] = a[8*(e*eb+q) +: 8];
          bl[8*q +: 8] = b[8*(e*eb+q) +: 8];
        end
        r = op ? (al + bl) : (al - bl);
        sum[8*(e*eb+j) +: 8] = r[8*j +: 8];
        cv[e*eb+j+1] = op ? r[8*(j+1)] : (al < bl);
        if (j == eb - 1) pk[e] = op ? r[8*(j+1)] : (al < bl);
      end
    end
  endtask

  typedef struct {
    int            avail;
    logic [255:0]  data;
    logic [31:0]   carry;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t         exp_q[$];
  int           outst_m   = 0;
  logic [3:0]   cfg_m     = 4'b1000;
  int           last_fire = 0;
  bit           have_fire = 1'b0;
  bit           live      = 1'b0;
  logic [255:0] rec_sum  [64];
  logic [32:0]  rec_cout [64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      rec_sum[i]  = '0;
      rec_cout[i] = '0;
    end
  end

  // Model step, per-cycle compare, then drive the adder outputs for this cycle.
  always @(negedge clk_i) begin : mdl
    logic [255:0] s_now;
    logic [32:0]  c_now;
    logic [31:0]  pk_now;
    logic [255:0] sd;
    logic [32:0]  cd;
    bit busy_m, ready_m, valid_m, fire_m, pop_m;
    int idx;
    exp_t e;
    adder_model(issue_op_i, issue_sew_i, a_in, b_in, s_now, c_now, pk_now);
    if (rst_i) begin
      exp_q.delete();
      outst_m   = 0;
      cfg_m     = 4'b1000;
      have_fire = 1'b0;
      live      = 1'b1;
    end else if (live) begin
      busy_m  = have_fire && (cyc - last_fire >= 1) && (cyc - last_fire <= 31);
      ready_m = (outst_m < DEPTH) && !(busy_m && ({issue_op_i, issue_sew_i} != cfg_m));
      valid_m = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      fire_m  = issue_valid_i && ready_m;
      pop_m   = valid_m && result_ready_i;
      check("issue_ready", issue_ready_o, ready_m);
      check("result_valid", result_valid_o, valid_m);
      check("addsub_en", addsub_en_o, fire_m || busy_m);
      check("addsub_op", addsub_op_o, fire_m ? issue_op_i : cfg_m[3]);
      check("addsub_sew", addsub_sew_o, fire_m ? issue_sew_i : cfg_m[2:0]);
      if (valid_m) begin
        check("head_data", result_data_o, exp_q[0].data);
        check("head_carry", result_carry_o, exp_q[0].carry);
        check("head_tag", result_tag_o, exp_q[0].tag);
      end else begin
        check("idle_data", result_data_o, 0);
        check("idle_carry", result_carry_o, 0);
        check("idle_tag", result_tag_o, 0);
      end
      if (pop_m) void'(exp_q.pop_front());
      if (fire_m) begin
        e.avail = cyc + 33;
        e.data  = s_now;
        e.carry = pk_now;
        e.tag   = issue_tag_i;
        exp_q.push_back(e);
        last_fire = cyc;
        have_fire = 1'b1;
        cfg_m     = {issue_op_i, issue_sew_i};
      end
      outst_m = outst_m + int'(fire_m) - int'(pop_m);
    end
    rec_sum[cyc & 63]  = s_now;
    rec_cout[cyc & 63] = c_now;
    sd = '0;
    cd = '0;
    for (int p = 0; p < 32; p++) begin
      idx = (cyc - p) & 63;
      sd[8*p +: 8] = rec_sum[idx][8*p +: 8];
      cd[p+1]      = rec_cout[idx][p+1];
    end
    sum_i  = sd;
    cout_i = cd;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic op, input logic [2:0] sew, input logic [TW-1:0] tag,
                       input logic [255:0] a, input logic [255:0] b, output int fc);
    bit done;
    issue_valid_i = 1'b1;
    issue_op_i    = op;
    issue_sew_i   = sew;
    issue_tag_i   = tag;
    a_in          = a;
    b_in          = b;
    fc   = -1;
    done = 1'b0;
    for (int n = 0; n < 80 && !done; n++) begin
      #1;
      if (issue_ready_o) begin
        fc   = cyc;
        done = 1'b1;
      end
      tick();
    end
    issue_valid_i = 1'b0;
    check("issue_accepted", done, 1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!result_valid_o && n < 80) begin
      tick();
      n++;
    end
    check(name, result_valid_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int fc;
    int fc2;
    int t0;
    int nf;
    bit seen;
    logic [255:0] s;
    logic [32:0]  c;
    logic [31:0]  pk;

    rst_i          = 1'b1;
    issue_valid_i  = 1'b0;
    issue_op_i     = 1'b1;
    issue_sew_i    = 3'd0;
    issue_tag_i    = '0;
    a_in           = '0;
    b_in           = '0;
    result_ready_i = 1'b1;

    adder_model(1'b1, 3'd0, {32{8'hFF}}, {32{8'h01}}, s, c, pk);
    check("pin_add8_sum", s, 0);
    check("pin_add8_carry", pk, 32'hFFFF_FFFF);
    adder_model(1'b1, 3'd5, {256{1'b1}}, 256'd1, s, c, pk);
    check("pin_add256_sum", s, 0);
    check("pin_add256_carry", pk, 32'h0000_0001);
    adder_model(1'b0, 3'd2, 256'd0, {8{32'h1}}, s, c, pk);
    check("pin_sub32_sum", s, {8{32'hFFFF_FFFF}});
    check("pin_sub32_carry", pk, 32'h0000_00FF);

    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    check("rst_ready", issue_ready_o, 1);
    check("rst_valid", result_valid_o, 0);
    check("rst_en", addsub_en_o, 0);
    check("rst_op", addsub_op_o, 1);
    check("rst_sew", addsub_sew_o, 0);
    check("rst_data", result_data_o, 0);
    tick();

    // single add, 8-bit elements
    issue(1'b1, 3'd0, 4'd3, {32{8'hFF}}, {32{8'h01}}, fc);
    wait_valid("t1_valid");
    check("t1_latency", cyc - fc, 33);
    check("t1_data", result_data_o, 0);
    check("t1_carry", result_carry_o, 32'hFFFF_FFFF);
    check("t1_tag", result_tag_o, 3);
    tick();

    // 256-bit packing
    issue(1'b1, 3'd5, 4'd5, {256{1'b1}}, 256'd1, fc);
    wait_valid("t2_valid");
    check("t2_latency", cyc - fc, 33);
    check("t2_data", result_data_o, 0);
    check("t2_carry", result_carry_o, 32'h0000_0001);
    check("t2_tag", result_tag_o, 5);
    tick();

    // 32-bit subtract with borrows
    issue(1'b0, 3'd2, 4'd6, 256'd0, {8{32'h1}}, fc);
    wait_valid("t3_valid");
    check("t3_data", result_data_o, {8{32'hFFFF_FFFF}});
    check("t3_carry", result_carry_o, 32'h0000_00FF);
    check("t3_tag", result_tag_o, 6);
    tick();

    // credit stall with a blocked consumer
    result_ready_i = 1'b0;
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      issue_valid_i = 1'b1;
      issue_op_i    = 1'b1;
      issue_sew_i   = 3'd0;
      issue_tag_i   = TW'(4 + i);
      a_in          = {32{8'(16 * i + 1)}};
      b_in          = {32{8'h11}};
      #1;
      if (issue_ready_o) nf++;
      tick();
    end
    issue_valid_i = 1'b0;
    check("credit_fires", nf, 4);
    wait_valid("t4_valid");
    repeat (5) tick();
    check("credit_hold_ready", issue_ready_o, 0);
    check("credit_hold_tag", result_tag_o, 4);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("credit_release", issue_ready_o, 1);
    check("credit_next_tag", result_tag_o, 5);
    result_ready_i = 1'b1;
    for (int k = 5; k < 8; k++) begin
      wait_valid("t4_drain_valid");
      check("credit_order_tag", result_tag_o, k);
      tick();
    end
    repeat (2) tick();

    // interlock on config change while busy
    issue(1'b1, 3'd0, 4'd10, {32{8'h10}}, {32{8'h20}}, t0);
    issue_valid_i = 1'b1;
    issue_op_i    = 1'b0;
    issue_sew_i   = 3'd0;
    issue_tag_i   = 4'd11;
    a_in          = {32{8'h05}};
    b_in          = {32{8'h07}};
    fc2 = -1;
    for (int n = 0; n < 60 && fc2 < 0; n++) begin
      #1;
      if (issue_ready_o) begin
        fc2 = cyc;
      end else begin
        check("ilock_op_held", addsub_op_o, 1);
      end
      tick();
    end
    issue_valid_i = 1'b0;
    check("ilock_fire_delay", fc2 - t0, 32);
    wait_valid("t5a_valid");
    check("t5a_data", result_data_o, {32{8'h30}});
    check("t5a_carry", result_carry_o, 0);
    check("t5a_tag", result_tag_o, 10);
    tick();
    wait_valid("t5b_valid");
    check("t5b_data", result_data_o, {32{8'hFE}});
    check("t5b_carry", result_carry_o, 32'hFFFF_FFFF);
    check("t5b_tag", result_tag_o, 11);
    tick();
    repeat (2) tick();

    // reset with two ops in flight
    t0 = cyc;
    issue_valid_i = 1'b1;
    issue_op_i    = 1'b0;
    issue_sew_i   = 3'd0;
    issue_tag_i   = 4'd12;
    a_in          = {32{8'h44}};
    b_in          = {32{8'h11}};
    tick();
    issue_tag_i   = 4'd13;
    tick();
    issue_valid_i = 1'b0;
    while (cyc < t0 + 10) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("mid_rst_ready", issue_ready_o, 1);
    check("mid_rst_outstanding", dut.outstanding_q, 0);
    check("mid_rst_en", addsub_en_o, 0);
    seen = 1'b0;
    repeat (60) begin
      if (result_valid_o) seen = 1'b1;
      tick();
    end
    check("mid_rst_no_result", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
